// File: rtl/nibble_serial_adder.sv
// Purpose : WIDTH-bit adder sequenced one nibble per clock through an external 4-bit adder slice.
// Latency : out_valid rises WIDTH/4 cycles after the accepting edge; one op per WIDTH/4+2 cycles at best.
// Backpressure: in_ready low outside IDLE (nothing queued); DONE holds SUM/COUT/OVF until out_ready.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake for A, B, Cin
//   NA, NB, NCI       nibble operands and carry-in presented to the adder slice
//   NS, NCO           slice sum and carry-out (combinational from NA/NB/NCI)
//   out_valid/out_ready result handshake for SUM, COUT, OVF
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [3:0]       NA,
    output logic [3:0]       NB,
    output logic             NCI,
    input  logic [3:0]       NS,
    input  logic             NCO,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    // Only the lower NIB-1 nibbles are stored; the top nibble goes
    // straight from NS into SUM on the final step.
    logic [WIDTH-5:0] partial_q;
    logic             last_step;

    assign last_step = (idx_q == IW'(NIB - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake flags and slice drive
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        NA        = 4'h0;
        NB        = 4'h0;
        NCI       = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int n = 0; n < NIB; n++) begin
                    if (idx_q == IW'(n)) begin
                        NA = a_q[4*n +: 4];
                        NB = b_q[4*n +: 4];
                    end
                end
                NCI = carry_q;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, nibble accumulation and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            partial_q <= '0;
            SUM       <= '0;
            COUT      <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= Cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    carry_q <= NCO;
                    for (int n = 0; n < NIB - 1; n++) begin
                        if (idx_q == IW'(n)) begin
                            partial_q[4*n +: 4] <= NS;
                        end
                    end
                    if (last_step) begin
                        SUM   <= {NS, partial_q};
                        COUT  <= NCO;
                        // Signed overflow: like-signed operands, result sign differs
                        OVF   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (NS[3] != a_q[WIDTH-1]);
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Purpose : self-checking bench for nibble_serial_adder with a behavioural slice and reference model.
// Latency : checks out_valid exactly NIB cycles after the accepting edge.
// Backpressure: holds out_ready low in DONE and pulses in_valid while busy.
module tb_nibble_serial_adder;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic [3:0]   NA;
    logic [3:0]   NB;
    logic         NCI;
    logic [3:0]   NS;
    logic         NCO;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] SUM;
    logic         COUT;
    logic         OVF;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Behavioural 4-bit adder slice
    always_comb begin
        logic [4:0] t;
        t   = {1'b0, NA} + {1'b0, NB} + {4'b0, NCI};
        NS  = t[3:0];
        NCO = t[4];
    end

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .NA        (NA),
        .NB        (NB),
        .NCI       (NCI),
        .NS        (NS),
        .NCO       (NCO),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SUM       (SUM),
        .COUT      (COUT),
        .OVF       (OVF)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: full-precision arithmetic on the operands
    function automatic logic [W:0] ref_total(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        return (s > 32767) || (s < -32768);
    endfunction

    // Carry entering nibble i: carry out of the low 4*i bits of a+b+c
    function automatic logic ref_nib_carry(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int i);
        longint mask;
        longint t;
        if (i == 0) return c;
        mask = (longint'(1) << (4 * i)) - 1;
        t = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
        return t[4*i];
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int hold, input bit pulse);
        logic [W:0] tot;
        logic       ovf;
        logic [W-1:0] nib_mask;
        tot = ref_total(a, b, c);
        ovf = ref_ovf(a, b, c);
        nib_mask = W'(16'h000F);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        A = a;
        B = b;
        Cin = c;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            // Operands are scrambled after acceptance; the DUT must have captured them
            A = W'($urandom);
            B = W'($urandom);
            Cin = 1'($urandom);
            in_valid = pulse ? 1'($urandom) : 1'b0;
            chk("na_step", NA, 32'((a >> (4 * i)) & nib_mask));
            chk("nb_step", NB, 32'((b >> (4 * i)) & nib_mask));
            chk("nci_step", NCI, ref_nib_carry(a, b, c, i));
            chk("out_valid_run", out_valid, 0);
            chk("in_ready_run", in_ready, 0);
            @(negedge clk);
        end
        chk("out_valid_done", out_valid, 1);
        chk("sum", SUM, 32'(tot[W-1:0]));
        chk("cout", COUT, tot[W]);
        chk("ovf", OVF, ovf);
        chk("in_ready_done", in_ready, 0);
        chk("na_done", NA, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = pulse ? 1'b1 : 1'b0;
            A = W'($urandom);
            B = W'($urandom);
            @(negedge clk);
            chk("out_valid_hold", out_valid, 1);
            chk("sum_hold", SUM, 32'(tot[W-1:0]));
            chk("in_ready_hold", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_after", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("sum_after", SUM, 32'(tot[W-1:0]));
        chk("cout_after", COUT, tot[W]);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        A = '0;
        B = '0;
        Cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", SUM, 0);
        chk("rst_cout", COUT, 0);
        chk("rst_ovf", OVF, 0);
        chk("rst_na", NA, 0);
        chk("rst_nci", NCI, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_post_rst", in_ready, 1);

        // Directed cases
        do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 2, 1'b0);
        do_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
        // Back-pressure with in_valid pulses during RUN and DONE
        do_op(16'hA5A5, 16'h1111, 1'b0, 6, 1'b1);

        // Reset during the second RUN cycle
        @(negedge clk);
        in_valid = 1'b1;
        A = 16'hDEAD;
        B = 16'hBEEF;
        Cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", SUM, 0);
        chk("midrst_cout", COUT, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_na", NA, 0);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready_rel", in_ready, 1);
        repeat (N + 1) begin
            @(negedge clk);
            chk("midrst_no_result", out_valid, 0);
        end
        do_op(16'h00FF, 16'h0F01, 1'b0, 0, 1'b0);

        // rst together with in_valid: operand must not be taken
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        A = 16'h1111;
        B = 16'h2222;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_vs_valid_idle", in_ready, 1);
        repeat (N + 1) begin
            @(negedge clk);
            chk("rst_vs_valid_no_result", out_valid, 0);
        end

        // Randomized operations
        for (int k = 0; k < 200; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (k % 10 == 0) ra = 16'hFFFF;
            if (k % 10 == 1) rb = 16'h8000;
            do_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
